// File: rtl/ram_ctrl_if.sv
// Request / write-data / read-data streams between a requester and ram_ctrl.
//   req_*  : burst request (valid/ready), req_wr selects write or read,
//            req_addr is the start address, req_len is beats minus one
//   wr_*   : write data beats (valid/ready)
//   rd_*   : read data beats (valid/ready), rd_last marks the final beat
// master = requester side, slave = controller side.
interface ram_ctrl_if #(
    parameter int addr_size = 4,
    parameter int word_size = 8
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_wr;
    logic [addr_size-1:0] req_addr;
    logic [addr_size-1:0] req_len;
    logic                 wr_valid;
    logic                 wr_ready;
    logic [word_size-1:0] wr_data;
    logic                 rd_valid;
    logic                 rd_ready;
    logic [word_size-1:0] rd_data;
    logic                 rd_last;

    modport master (
        output req_valid, req_wr, req_addr, req_len, wr_valid, wr_data, rd_ready,
        input  req_ready, wr_ready, rd_valid, rd_data, rd_last
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_len, wr_valid, wr_data, rd_ready,
        output req_ready, wr_ready, rd_valid, rd_data, rd_last
    );
endinterface

// File: rtl/ram_ctrl.sv
// Sequencing controller in front of the asynchronous ram block.
// Accepts single/burst read and write requests, drives cs/wr/addr/data_in
// with one cycle of setup before each write strobe, and returns read data
// on a valid/ready stream. Burst addresses wrap modulo memory_size.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   bus          : request / write-data / read-data streams (slave side)
//   err          : one-cycle pulse when a request has an out-of-range address
//   busy         : high whenever the controller is not idle
//   ram_addr, ram_data_in, ram_wr, ram_cs : registered RAM controls
//   ram_data_out : RAM read data (combinational from ram_addr)
module ram_ctrl #(
    parameter int addr_size   = 4,
    parameter int word_size   = 8,
    parameter int memory_size = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    ram_ctrl_if.slave            bus,
    output logic                 err,
    output logic                 busy,
    output logic [addr_size-1:0] ram_addr,
    output logic [word_size-1:0] ram_data_in,
    input  logic [word_size-1:0] ram_data_out,
    output logic                 ram_wr,
    output logic                 ram_cs
);
    typedef enum logic [2:0] {
        IDLE, WR_WAIT, WR_SETUP, WR_STROBE, RD_ADDR, RD_SAMPLE, RD_HOLD
    } state_t;

    // One extra bit so memory_size == 2**addr_size still compares correctly.
    localparam logic [addr_size:0]   MEM_SIZE = (addr_size+1)'(memory_size);
    localparam logic [addr_size-1:0] LAST     = addr_size'(memory_size - 1);

    state_t               state, state_n;
    logic [addr_size-1:0] cur_addr, cur_addr_n;
    logic [addr_size-1:0] len, len_n;
    logic [addr_size-1:0] beat, beat_n;
    logic [addr_size-1:0] ram_addr_n;
    logic [word_size-1:0] ram_data_in_n;
    logic                 ram_wr_n, ram_cs_n;
    logic                 rd_valid_n, rd_last_n;
    logic [word_size-1:0] rd_data_n;
    logic                 err_n;

    // memory_size need not be a power of two, so wrap explicitly.
    function automatic logic [addr_size-1:0] inc(input logic [addr_size-1:0] a);
        return (a == LAST) ? '0 : a + 1'b1;
    endfunction

    assign bus.req_ready = (state == IDLE) && !rst;
    assign bus.wr_ready  = (state == WR_WAIT);
    assign busy          = (state != IDLE);

    always_comb begin
        state_n       = state;
        cur_addr_n    = cur_addr;
        len_n         = len;
        beat_n        = beat;
        ram_addr_n    = ram_addr;
        ram_data_in_n = ram_data_in;
        ram_wr_n      = ram_wr;
        ram_cs_n      = ram_cs;
        rd_valid_n    = bus.rd_valid;
        rd_data_n     = bus.rd_data;
        rd_last_n     = bus.rd_last;
        err_n         = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    if ({1'b0, bus.req_addr} >= MEM_SIZE) begin
                        err_n = 1'b1;
                    end else begin
                        cur_addr_n = bus.req_addr;
                        len_n      = bus.req_len;
                        beat_n     = '0;
                        state_n    = bus.req_wr ? WR_WAIT : RD_ADDR;
                    end
                end
            end
            WR_WAIT: begin
                if (bus.wr_valid) begin
                    ram_data_in_n = bus.wr_data;
                    ram_addr_n    = cur_addr;
                    ram_cs_n      = 1'b1;
                    ram_wr_n      = 1'b0;
                    state_n       = WR_SETUP;
                end
            end
            WR_SETUP: begin
                ram_wr_n = 1'b1;
                state_n  = WR_STROBE;
            end
            WR_STROBE: begin
                ram_wr_n = 1'b0;
                ram_cs_n = 1'b0;
                if (beat == len) begin
                    state_n = IDLE;
                end else begin
                    beat_n     = beat + 1'b1;
                    cur_addr_n = inc(cur_addr);
                    state_n    = WR_WAIT;
                end
            end
            RD_ADDR: begin
                ram_addr_n = cur_addr;
                ram_cs_n   = 1'b1;
                ram_wr_n   = 1'b0;
                state_n    = RD_SAMPLE;
            end
            RD_SAMPLE: begin
                rd_data_n  = ram_data_out;
                rd_valid_n = 1'b1;
                rd_last_n  = (beat == len);
                ram_cs_n   = 1'b0;
                state_n    = RD_HOLD;
            end
            RD_HOLD: begin
                if (bus.rd_ready) begin
                    rd_valid_n = 1'b0;
                    rd_last_n  = 1'b0;
                    if (bus.rd_last) begin
                        state_n = IDLE;
                    end else begin
                        beat_n     = beat + 1'b1;
                        cur_addr_n = inc(cur_addr);
                        state_n    = RD_ADDR;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cur_addr     <= '0;
            len          <= '0;
            beat         <= '0;
            ram_addr     <= '0;
            ram_data_in  <= '0;
            ram_wr       <= 1'b0;
            ram_cs       <= 1'b0;
            bus.rd_valid <= 1'b0;
            bus.rd_data  <= '0;
            bus.rd_last  <= 1'b0;
            err          <= 1'b0;
        end else begin
            state        <= state_n;
            cur_addr     <= cur_addr_n;
            len          <= len_n;
            beat         <= beat_n;
            ram_addr     <= ram_addr_n;
            ram_data_in  <= ram_data_in_n;
            ram_wr       <= ram_wr_n;
            ram_cs       <= ram_cs_n;
            bus.rd_valid <= rd_valid_n;
            bus.rd_data  <= rd_data_n;
            bus.rd_last  <= rd_last_n;
            err          <= err_n;
        end
    end
endmodule
